// File: rtl/ultrasonic_distance_proc.sv
// Echo pulse width to centimetre converter: restoring divider, saturation, hysteretic near flag.
// Optional 4-sample moving average enabled by defining DIST_AVG_EN.
module ultrasonic_distance_proc #(
    parameter int CYCLES_PER_CM = 2900,
    parameter int NEAR_CM       = 10,
    parameter int FAR_CM        = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] echo_counter_i,
    input  logic        echo_valid_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [7:0]  distance_cm_o,
    output logic        distance_valid_o,
    output logic        out_of_range_o,
    output logic        near_o
);

    localparam logic [16:0] DIVISOR = 17'(CYCLES_PER_CM);
    localparam logic [7:0]  NEAR_T  = 8'(NEAR_CM);
    localparam logic [7:0]  FAR_T   = 8'(FAR_CM);

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FILTER, S_OUTPUT} state_t;

    state_t      state_q, state_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic [4:0]  iter_q, iter_d;
    logic        sat_in_q, sat_in_d;
    logic [7:0]  d_q, d_d;
    logic [7:0]  dist_q, dist_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        oor_q, oor_d;
    logic        near_q, near_d;

    logic [16:0] rem_shift;
    logic [16:0] rem_diff;
    logic [7:0]  sat_value;
    logic [7:0]  out_value;

`ifdef DIST_AVG_EN
    logic [7:0] hist_q [4];
    logic [7:0] hist_d [4];
    logic       primed_q, primed_d;
    logic [9:0] hist_sum;

    // History is written in FILTER so OUTPUT sees the window including the new sample
    always_comb begin
        hist_d   = hist_q;
        primed_d = primed_q;
        if (state_q == S_FILTER) begin
            if (!primed_q) begin
                for (int i = 0; i < 4; i++) hist_d[i] = sat_value;
                primed_d = 1'b1;
            end else begin
                hist_d[3] = hist_q[2];
                hist_d[2] = hist_q[1];
                hist_d[1] = hist_q[0];
                hist_d[0] = sat_value;
            end
        end
        hist_sum  = 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]) + 10'(hist_q[3]);
        out_value = 8'(hist_sum >> 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            primed_q <= primed_d;
        end
    end
`else
    assign out_value = d_q;
`endif

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        iter_d    = iter_q;
        sat_in_d  = sat_in_q;
        d_d       = d_q;
        dist_d    = dist_q;
        valid_d   = 1'b0;
        oor_d     = oor_q;
        near_d    = near_q;
        overrun_d = echo_valid_i && (state_q != S_IDLE);

        // quot_q starts as the dividend and fills with quotient bits from the right
        rem_shift = {rem_q, quot_q[15]};
        rem_diff  = rem_shift - DIVISOR;
        sat_value = (sat_in_q || quot_q > 16'd255) ? 8'hFF : quot_q[7:0];

        case (state_q)
            S_IDLE: begin
                if (echo_valid_i) begin
                    quot_d   = echo_counter_i;
                    rem_d    = '0;
                    iter_d   = 5'd16;
                    sat_in_d = (echo_counter_i == 16'hFFFF);
                    state_d  = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (rem_shift >= DIVISOR) begin
                    rem_d  = rem_diff[15:0];
                    quot_d = {quot_q[14:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[15:0];
                    quot_d = {quot_q[14:0], 1'b0};
                end
                iter_d = iter_q - 5'd1;
                if (iter_q == 5'd1) state_d = S_FILTER;
            end
            S_FILTER: begin
                d_d     = sat_value;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                dist_d  = out_value;
                oor_d   = sat_in_q;
                valid_d = 1'b1;
                if (sat_in_q)                near_d = 1'b0;
                else if (out_value <= NEAR_T) near_d = 1'b1;
                else if (out_value >= FAR_T)  near_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            quot_q    <= '0;
            rem_q     <= '0;
            iter_q    <= '0;
            sat_in_q  <= 1'b0;
            d_q       <= '0;
            dist_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            oor_q     <= 1'b0;
            near_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            iter_q    <= iter_d;
            sat_in_q  <= sat_in_d;
            d_q       <= d_d;
            dist_q    <= dist_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            oor_q     <= oor_d;
            near_q    <= near_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign overrun_o        = overrun_q;
    assign distance_cm_o    = dist_q;
    assign distance_valid_o = valid_q;
    assign out_of_range_o   = oor_q;
    assign near_o           = near_q;

endmodule

// File: tb/tb_ultrasonic_distance_proc.sv
// Self-checking bench for ultrasonic_distance_proc: directed and random samples
// checked against an arithmetic reference model (honours DIST_AVG_EN).
module tb_ultrasonic_distance_proc;

    localparam int CPC     = 2900;
    localparam int NEAR_CM = 10;
    localparam int FAR_CM  = 15;

    logic        clk;
    logic        rst;
    logic [15:0] echo_counter;
    logic        echo_valid;
    logic        busy;
    logic        overrun;
    logic [7:0]  distance_cm;
    logic        distance_valid;
    logic        out_of_range;
    logic        near;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state
    int modelHist [4];
    bit modelPrimed = 0;
    bit modelNear   = 0;

    ultrasonic_distance_proc #(
        .CYCLES_PER_CM(CPC),
        .NEAR_CM(NEAR_CM),
        .FAR_CM(FAR_CM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .echo_counter_i(echo_counter),
        .echo_valid_i(echo_valid),
        .busy_o(busy),
        .overrun_o(overrun),
        .distance_cm_o(distance_cm),
        .distance_valid_o(distance_valid),
        .out_of_range_o(out_of_range),
        .near_o(near)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        totalChecks++;
        if (actual != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model: distance = floor(width / CPC) saturated to 255; all-ones width is out of range
    task automatic modelUpdate(input int width, output int expDist, output bit expOor);
        int d;
        expOor = (width == 65535);
        d = expOor ? 255 : width / CPC;
        if (d > 255) d = 255;
`ifdef DIST_AVG_EN
        if (!modelPrimed) begin
            for (int i = 0; i < 4; i++) modelHist[i] = d;
            modelPrimed = 1;
        end else begin
            for (int i = 3; i > 0; i--) modelHist[i] = modelHist[i-1];
            modelHist[0] = d;
        end
        expDist = (modelHist[0] + modelHist[1] + modelHist[2] + modelHist[3]) / 4;
`else
        expDist = d;
`endif
        if (expOor)                modelNear = 0;
        else if (expDist <= NEAR_CM) modelNear = 1;
        else if (expDist >= FAR_CM)  modelNear = 0;
    endtask

    // Sends one sample; optionally fires a second strobe overrunAt edges after E0
    task automatic applyStimulus(input int width, input int overrunAt);
        int n;
        int busyCycles;
        int expDist;
        bit expOor;
        @(negedge clk);
        echo_counter = 16'(width);
        echo_valid   = 1'b1;
        @(posedge clk);
        #1;
        echo_valid = 1'b0;
        n = 0;
        busyCycles = busy ? 1 : 0;
        while (1) begin
            if (overrunAt != 0 && n + 1 == overrunAt) begin
                @(negedge clk);
                echo_counter = 16'($urandom);
                echo_valid   = 1'b1;
            end
            @(posedge clk);
            #1;
            echo_valid = 1'b0;
            n++;
            if (overrunAt != 0 && n == overrunAt) checkOutput("overrun_pulse", overrun, 1);
            if (overrunAt != 0 && n == overrunAt + 1) checkOutput("overrun_clear", overrun, 0);
            if (distance_valid || n > 40) break;
            if (busy) busyCycles++;
        end
        checkOutput("latency", n, 18);
        checkOutput("busy_cycles", busyCycles, 18);
        checkOutput("busy_idle", busy, 0);
        modelUpdate(width, expDist, expOor);
        checkOutput("distance", distance_cm, expDist);
        checkOutput("out_of_range", out_of_range, expOor);
        checkOutput("near", near, modelNear);
        if (overrunAt != 0) begin
            @(posedge clk);
            #1;
            checkOutput("valid_single", distance_valid, 0);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        modelPrimed = 0;
        modelNear   = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        echo_counter = '0;
        echo_valid   = 1'b0;
        #2;
        rst = 1'b0;
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_dist", distance_cm, 0);
        checkOutput("reset_valid", distance_valid, 0);
        checkOutput("reset_near", near, 0);
        checkOutput("reset_oor", out_of_range, 0);
        checkOutput("reset_overrun", overrun, 0);
        doReset();

        // Directed sequence across the hysteresis band, back to back
        applyStimulus(29000, 0);
        applyStimulus(43500, 0);
        applyStimulus(34800, 0);
        applyStimulus(29000, 0);
        applyStimulus(37700, 0);
        applyStimulus(43500, 0);
        applyStimulus(65535, 0);
        applyStimulus(0, 0);
        applyStimulus(65534, 0);

        // Overrun during DIVIDE and on the OUTPUT->IDLE edge
        applyStimulus(31900, 5);
        applyStimulus(52200, 18);
        applyStimulus(2899, 17);

        // Reset mid-DIVIDE aborts the conversion
        @(negedge clk);
        echo_counter = 16'd40000;
        echo_valid   = 1'b1;
        @(posedge clk);
        #1;
        echo_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_dist", distance_cm, 0);
        checkOutput("abort_near", near, 0);
        checkOutput("abort_valid", distance_valid, 0);
        modelPrimed = 0;
        modelNear   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_valid", distance_valid, 0);
        end
        applyStimulus(29000, 0);

        // Random samples biased toward the near/far band and saturation
        for (int i = 0; i < 40; i++) begin
            int mode;
            int w;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       w = $urandom_range(0, 65535);
                1:       w = $urandom_range(20000, 60000);
                2:       w = 65535;
                default: w = $urandom_range(0, 3000);
            endcase
            applyStimulus(w, 0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
